// File: rtl/bsg_counter_up_down_sat.sv
`default_nettype none
// ============================================================================
// Module   : bsg_counter_up_down_sat
// Purpose  : Saturating up/down counter. It supports load, sticky
//            overflow/underflow flags, and registered full/empty status.
//            When BSG_COUNTER_UP_DOWN_SAT_THRESH_EN is defined, the module
//            adds the thresh_p parameter and a registered thresh_o output.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_counter_up_down_sat #(
    parameter int max_val_p  = 10000000,
    parameter int init_val_p = 100,
    parameter int max_step_p = 4,
`ifdef BSG_COUNTER_UP_DOWN_SAT_THRESH_EN
    parameter int thresh_p   = max_val_p / 2,
`endif
    localparam int cnt_w = $clog2(max_val_p + 1),
    localparam int stp_w = $clog2(max_step_p + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [stp_w-1:0] up_i,
    input  logic [stp_w-1:0] down_i,
    input  logic             load_v_i,
    input  logic [cnt_w-1:0] load_val_i,
    input  logic             err_clr_i,
    output logic [cnt_w-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
`ifdef BSG_COUNTER_UP_DOWN_SAT_THRESH_EN
    output logic             thresh_o,
`endif
    output logic             underflow_o
);

    localparam int                      c_pad     = cnt_w + 2 - stp_w;
    localparam logic [cnt_w-1:0]        c_max     = cnt_w'(max_val_p);
    localparam logic [cnt_w-1:0]        c_init    = cnt_w'(init_val_p);
    localparam logic signed [cnt_w+1:0] c_max_s   = (cnt_w + 2)'(max_val_p);
    localparam logic                    c_full_r  = (init_val_p == max_val_p);
    localparam logic                    c_empty_r = (init_val_p == 0);

    logic [cnt_w-1:0]        count_q, count_d;
    logic                    full_q, empty_q, overflow_q, underflow_q;
    logic                    overflow_d, underflow_d;
    logic                    ovf_set, unf_set;
    logic signed [cnt_w+1:0] sum;

    // Two guard bits keep the signed net sum exact, so it can never wrap before the clamp.
    always_comb begin
        sum = $signed({2'b00, count_q})
            - $signed({{c_pad{1'b0}}, down_i})
            + $signed({{c_pad{1'b0}}, up_i});
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (load_v_i) begin
            if (load_val_i > c_max) begin
                count_d = c_max;
                ovf_set = 1'b1;
            end else begin
                count_d = load_val_i;
            end
        end else if (sum[cnt_w+1]) begin
            count_d = '0;
            unf_set = 1'b1;
        end else if (sum > c_max_s) begin
            count_d = c_max;
            ovf_set = 1'b1;
        end else begin
            count_d = sum[cnt_w-1:0];
        end
        overflow_d  = ovf_set | (overflow_q  & ~err_clr_i);
        underflow_d = unf_set | (underflow_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q     <= c_init;
            full_q      <= c_full_r;
            empty_q     <= c_empty_r;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= (count_d == c_max);
            empty_q     <= (count_d == '0);
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

`ifdef BSG_COUNTER_UP_DOWN_SAT_THRESH_EN
    localparam logic [cnt_w-1:0] c_thresh   = cnt_w'(thresh_p);
    localparam logic             c_thresh_r = (init_val_p >= thresh_p);

    logic thresh_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            thresh_q <= c_thresh_r;
        end else begin
            thresh_q <= (count_d >= c_thresh);
        end
    end

    assign thresh_o = thresh_q;
`endif

endmodule
`default_nettype wire
